// File: rtl/sram_port0_arbiter.sv
// sram_port0_arbiter: shares SRAM port 0 between requesters A and B.
// Round-robin with optional burst lock, registered active-low controls.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   a_req/a_lock/a_we     A command request, burst lock, write(1)/read(0)
//   a_addr/a_wdata        A command address and write data
//   a_gnt                 A command accepted this cycle (combinational)
//   a_rvalid/a_rdata      A read return pulse and data (data holds)
//   b_*                   B mirror of the a_* ports
//   cs0_n/we0_n           SRAM port0 chip select / write enable (registered)
//   addr0/wdata0          SRAM port0 address / write data (registered)
//   rdata0                SRAM port0 read data
module sram_port0_arbiter #(
    parameter int ASIZE  = 10,
    parameter int DSIZE  = 8,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_req,
    input  logic             a_lock,
    input  logic             a_we,
    input  logic [ASIZE-1:0] a_addr,
    input  logic [DSIZE-1:0] a_wdata,
    output logic             a_gnt,
    output logic             a_rvalid,
    output logic [DSIZE-1:0] a_rdata,
    input  logic             b_req,
    input  logic             b_lock,
    input  logic             b_we,
    input  logic [ASIZE-1:0] b_addr,
    input  logic [DSIZE-1:0] b_wdata,
    output logic             b_gnt,
    output logic             b_rvalid,
    output logic [DSIZE-1:0] b_rdata,
    output logic             cs0_n,
    output logic             we0_n,
    output logic [ASIZE-1:0] addr0,
    output logic [DSIZE-1:0] wdata0,
    input  logic [DSIZE-1:0] rdata0
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_A,
        OWN_B
    } owner_t;

    owner_t           owner_q;
    owner_t           owner_d;
    logic             last_b_q;
    logic             lock_a;
    logic             lock_b;
    logic             gnt_any;
    logic             sel_we;
    logic             rd_gnt;
    logic [ASIZE-1:0] sel_addr;
    logic [DSIZE-1:0] sel_wdata;

    // Read tag pipe: bit 0 entered on the grant edge, top bit lines up
    // with the cycle whose closing edge samples rdata0.
    logic [RD_LAT:0]  tag_v;
    logic [RD_LAT:0]  tag_id;

    // Ownership is only honoured while the owner keeps both req and lock
    // high, so dropping either hands the port back in the same cycle.
    always_comb begin
        a_gnt   = 1'b0;
        b_gnt   = 1'b0;
        owner_d = OWN_NONE;
        lock_a  = (owner_q == OWN_A) && a_req && a_lock;
        lock_b  = (owner_q == OWN_B) && b_req && b_lock;
        if (lock_a) begin
            a_gnt = 1'b1;
        end else if (lock_b) begin
            b_gnt = 1'b1;
        end else if (a_req && b_req) begin
            if (last_b_q) begin
                a_gnt = 1'b1;
            end else begin
                b_gnt = 1'b1;
            end
        end else if (a_req) begin
            a_gnt = 1'b1;
        end else if (b_req) begin
            b_gnt = 1'b1;
        end
        if (a_gnt && a_lock) begin
            owner_d = OWN_A;
        end else if (b_gnt && b_lock) begin
            owner_d = OWN_B;
        end
    end

    always_comb begin
        gnt_any   = a_gnt | b_gnt;
        sel_we    = b_gnt ? b_we    : a_we;
        sel_addr  = b_gnt ? b_addr  : a_addr;
        sel_wdata = b_gnt ? b_wdata : a_wdata;
        rd_gnt    = gnt_any & ~sel_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= OWN_NONE;
            last_b_q <= 1'b1;
        end else begin
            owner_q <= owner_d;
            if (gnt_any) begin
                last_b_q <= b_gnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs0_n  <= 1'b1;
            we0_n  <= 1'b1;
            addr0  <= '0;
            wdata0 <= '0;
        end else if (gnt_any) begin
            cs0_n  <= 1'b0;
            we0_n  <= ~sel_we;
            addr0  <= sel_addr;
            wdata0 <= sel_wdata;
        end else begin
            cs0_n <= 1'b1;
            we0_n <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v  <= {tag_v[RD_LAT-1:0], rd_gnt};
            tag_id <= {tag_id[RD_LAT-1:0], b_gnt};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            if (tag_v[RD_LAT]) begin
                if (tag_id[RD_LAT]) begin
                    b_rvalid <= 1'b1;
                    b_rdata  <= rdata0;
                end else begin
                    a_rvalid <= 1'b1;
                    a_rdata  <= rdata0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// tb_sram_port0_arbiter: directed and random stimulus against a
// grant-order scoreboard, plus a deeper-latency instance.
module tb_sram_port0_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 8;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          a_req, a_lock, a_we, a_gnt, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_req, b_lock, b_we, b_gnt, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;
    logic          cs0_n, we0_n;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0, rdata0;

    logic          l3_a_req, l3_a_lock, l3_a_we, l3_a_gnt, l3_a_rvalid;
    logic [AW-1:0] l3_a_addr;
    logic [DW-1:0] l3_a_wdata, l3_a_rdata;
    logic          l3_b_req, l3_b_lock, l3_b_we, l3_b_gnt, l3_b_rvalid;
    logic [AW-1:0] l3_b_addr;
    logic [DW-1:0] l3_b_wdata, l3_b_rdata;
    logic          l3_cs0_n, l3_we0_n;
    logic [AW-1:0] l3_addr0;
    logic [DW-1:0] l3_wdata0, l3_rdata0;

    sram_port0_arbiter #(.ASIZE(AW), .DSIZE(DW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_lock(a_lock), .a_we(a_we),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt),
        .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_lock(b_lock), .b_we(b_we),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt),
        .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .cs0_n(cs0_n), .we0_n(we0_n), .addr0(addr0),
        .wdata0(wdata0), .rdata0(rdata0)
    );

    sram_port0_arbiter #(.ASIZE(AW), .DSIZE(DW), .RD_LAT(LAT3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .a_req(l3_a_req), .a_lock(l3_a_lock), .a_we(l3_a_we),
        .a_addr(l3_a_addr), .a_wdata(l3_a_wdata), .a_gnt(l3_a_gnt),
        .a_rvalid(l3_a_rvalid), .a_rdata(l3_a_rdata),
        .b_req(l3_b_req), .b_lock(l3_b_lock), .b_we(l3_b_we),
        .b_addr(l3_b_addr), .b_wdata(l3_b_wdata), .b_gnt(l3_b_gnt),
        .b_rvalid(l3_b_rvalid), .b_rdata(l3_b_rdata),
        .cs0_n(l3_cs0_n), .we0_n(l3_we0_n), .addr0(l3_addr0),
        .wdata0(l3_wdata0), .rdata0(l3_rdata0)
    );

    // Initial SRAM contents; address 0x005 holds 0x3C.
    function automatic logic [DW-1:0] finit(int i);
        return DW'(i * 13 + 251);
    endfunction

    // SRAM models: capture on the edge where cs0_n is low, data RD_LAT
    // cycles later.
    bit            mem_ready;
    logic [DW-1:0] mem  [1<<AW];
    logic [DW-1:0] mem3 [1<<AW];
    logic [DW-1:0] rp1;
    logic [DW-1:0] rp3 [3];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < (1 << AW); i++) begin
                mem[i]  <= finit(i);
                mem3[i] <= finit(i);
            end
            mem_ready <= 1'b1;
        end else begin
            if (!cs0_n && !we0_n) mem[addr0] <= wdata0;
            if (!cs0_n && we0_n) rp1 <= mem[addr0];
            if (!l3_cs0_n && !l3_we0_n) mem3[l3_addr0] <= l3_wdata0;
            rp3[0] <= mem3[l3_addr0];
            rp3[1] <= rp3[0];
            rp3[2] <= rp3[1];
        end
    end

    assign rdata0    = rp1;
    assign l3_rdata0 = rp3[2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state: who won last, who owns a burst, expected
    // SRAM control values and a grant-ordered read return queue.
    int            cycle;
    int            mlast;
    int            mown;
    int            last_win;
    logic          e_cs, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_ard, e_brd;
    logic [DW-1:0] shadow [1<<AW];
    int            q_due [$];
    bit            q_id  [$];
    logic [DW-1:0] q_dat [$];

    task automatic model_reset();
        mlast  = 1;
        mown   = -1;
        e_cs   = 1'b1;
        e_we   = 1'b1;
        e_addr = '0;
        e_wd   = '0;
        e_ard  = '0;
        e_brd  = '0;
        q_due.delete();
        q_id.delete();
        q_dat.delete();
    endtask

    // One clock cycle: inputs already applied; check at the falling edge.
    task automatic cyc();
        int            win;
        logic          ev_a, ev_b, wwe, wlk;
        logic [AW-1:0] wad;
        logic [DW-1:0] wwd;
        @(negedge clk);
        check("cs0_n", cs0_n, e_cs);
        check("we0_n", we0_n, e_we);
        check("addr0", addr0, e_addr);
        check("wdata0", wdata0, e_wd);
        ev_a = 1'b0;
        ev_b = 1'b0;
        if (q_due.size() != 0 && q_due[0] == cycle) begin
            if (q_id[0]) begin
                ev_b  = 1'b1;
                e_brd = q_dat[0];
            end else begin
                ev_a  = 1'b1;
                e_ard = q_dat[0];
            end
            q_due.delete(0);
            q_id.delete(0);
            q_dat.delete(0);
        end
        check("a_rvalid", a_rvalid, ev_a);
        check("b_rvalid", b_rvalid, ev_b);
        check("a_rdata", a_rdata, e_ard);
        check("b_rdata", b_rdata, e_brd);
        win = -1;
        if (mown == 0 && a_req && a_lock) win = 0;
        else if (mown == 1 && b_req && b_lock) win = 1;
        else if (a_req && b_req) win = 1 - mlast;
        else if (a_req) win = 0;
        else if (b_req) win = 1;
        check("a_gnt", a_gnt, win == 0);
        check("b_gnt", b_gnt, win == 1);
        last_win = win;
        if (win >= 0) begin
            wwe    = (win == 1) ? b_we    : a_we;
            wlk    = (win == 1) ? b_lock  : a_lock;
            wad    = (win == 1) ? b_addr  : a_addr;
            wwd    = (win == 1) ? b_wdata : a_wdata;
            mlast  = win;
            mown   = wlk ? win : -1;
            e_cs   = 1'b0;
            e_we   = ~wwe;
            e_addr = wad;
            e_wd   = wwd;
            if (wwe) begin
                shadow[wad] = wwd;
            end else begin
                q_due.push_back(cycle + LAT + 2);
                q_id.push_back(win == 1);
                q_dat.push_back(shadow[wad]);
            end
        end else begin
            mown = -1;
            e_cs = 1'b1;
            e_we = 1'b1;
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) shadow[i] = finit(i);
        rst_n   = 1'b0;
        {a_req, a_lock, a_we, a_addr, a_wdata} = '0;
        {b_req, b_lock, b_we, b_addr, b_wdata} = '0;
        {l3_a_req, l3_a_lock, l3_a_we, l3_a_addr, l3_a_wdata} = '0;
        {l3_b_req, l3_b_lock, l3_b_we, l3_b_addr, l3_b_wdata} = '0;
        model_reset();
        last_win = -1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs0_n", cs0_n, 1'b1);
        check("rst_we0_n", we0_n, 1'b1);
        check("rst_addr0", addr0, '0);
        check("rst_wdata0", wdata0, '0);
        check("rst_a_rvalid", a_rvalid, 1'b0);
        check("rst_b_rdata", b_rdata, '0);
        check("rst_l3_cs0_n", l3_cs0_n, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle = 0;

        // A single read from 0x005
        a_req  = 1'b1;
        a_addr = 10'h005;
        cyc();
        a_req = 1'b0;
        repeat (4) cyc();
        check("t1_a_rdata", a_rdata, 8'h3C);

        // Both requesting reads every cycle
        a_req  = 1'b1;
        b_req  = 1'b1;
        a_addr = 10'h020;
        b_addr = 10'h120;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (last_win == 0) a_addr = a_addr + 1'b1;
            if (last_win == 1) b_addr = b_addr + 1'b1;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (4) cyc();

        // Locked write burst from A with B waiting
        a_req   = 1'b1;
        a_lock  = 1'b1;
        a_we    = 1'b1;
        a_addr  = 10'h010;
        a_wdata = 8'h61;
        cyc();
        b_req  = 1'b1;
        b_we   = 1'b0;
        b_addr = 10'h011;
        for (int i = 1; i < 4; i++) begin
            a_addr  = AW'(10'h010 + i);
            a_wdata = DW'(8'h61 + i);
            cyc();
        end
        a_req  = 1'b0;
        a_lock = 1'b0;
        cyc();
        b_req = 1'b0;
        repeat (4) cyc();
        check("t3_b_rdata", b_rdata, 8'h62);

        // Write then read of the top address
        a_req   = 1'b1;
        a_we    = 1'b1;
        a_addr  = 10'h3FF;
        a_wdata = 8'hA5;
        cyc();
        a_req  = 1'b0;
        b_req  = 1'b1;
        b_we   = 1'b0;
        b_addr = 10'h3FF;
        cyc();
        b_req = 1'b0;
        repeat (4) cyc();
        check("t4_b_rdata", b_rdata, 8'hA5);

        // Random traffic; fields held until granted
        a_req    = 1'b0;
        b_req    = 1'b0;
        last_win = -1;
        for (int i = 0; i < 400; i++) begin
            if (last_win == 0 || !a_req) begin
                a_req   = ($urandom_range(0, 2) != 0);
                a_lock  = ($urandom_range(0, 3) == 0);
                a_we    = $urandom_range(0, 1) == 1;
                a_addr  = AW'($urandom_range(0, 15));
                a_wdata = DW'($urandom);
            end
            if (last_win == 1 || !b_req) begin
                b_req   = ($urandom_range(0, 2) != 0);
                b_lock  = ($urandom_range(0, 3) == 0);
                b_we    = $urandom_range(0, 1) == 1;
                b_addr  = AW'($urandom_range(0, 15));
                b_wdata = DW'($urandom);
            end
            cyc();
        end
        {a_req, a_lock, b_req, b_lock} = '0;
        repeat (5) cyc();

        // Reset right after an A read grant
        a_req  = 1'b1;
        a_we   = 1'b0;
        a_addr = 10'h007;
        cyc();
        a_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_cs0_n_async", cs0_n, 1'b1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle++;
        a_req  = 1'b1;
        b_req  = 1'b1;
        b_we   = 1'b0;
        a_addr = 10'h008;
        b_addr = 10'h009;
        cyc();
        check("t5_first_tie", last_win, 0);
        a_req = 1'b0;
        cyc();
        b_req = 1'b0;
        repeat (5) cyc();

        // RD_LAT=3 instance, back-to-back B reads
        for (int k = 0; k < 13; k++) begin
            l3_b_req  = (k < 6);
            l3_b_addr = AW'(k * 7 + 1);
            @(negedge clk);
            check("l3_b_gnt", l3_b_gnt, k < 6);
            check("l3_b_rvalid", l3_b_rvalid, k >= 5 && k <= 10);
            if (k >= 5 && k <= 10)
                check("l3_b_rdata", l3_b_rdata, finit((k - 5) * 7 + 1));
            check("l3_a_rvalid", l3_a_rvalid, 1'b0);
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
